// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the fixed-point divider.
//   state_e  - top-level sequencing states
//   div_iter - quotient bits produced per division (WIDTH + FBITS)
package div_pkg;

    typedef enum logic [2:0] {IDLE, CALC, ROUND, DONE, DBZ} state_e;

    // One quotient bit per cycle over the dividend pre-scaled by 2^FBITS.
    function automatic int div_iter(input int width, input int fbits);
        return width + fbits;
    endfunction

endpackage

// File: rtl/div_if.sv
// div_if: start/busy/done/valid handshake plus operand/result bus for div.
//   master - drives start, a, b; observes status and val
//   slave  - the divider side
interface div_if #(parameter int WIDTH = 8);
    logic             start;
    logic             busy;
    logic             done;
    logic             valid;
    logic             ovf;
    logic             dbz;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] val;

    modport master (output start, a, b,
                    input  busy, done, valid, ovf, dbz, val);
    modport slave  (input  start, a, b,
                    output busy, done, valid, ovf, dbz, val);
endinterface

// File: rtl/div_core_u.sv
// div_core_u: unsigned restoring divider, one quotient bit per clock.
//   clk, rst - clock, synchronous active-high reset
//   start    - load dvd_mag << FBITS and dvs_mag, begin iterating
//   dvd_mag  - dividend magnitude
//   dvs_mag  - divisor magnitude (non-zero)
//   q, r     - quotient (ITER bits) and remainder (WIDTH+1 bits)
//   done     - high in the cycle whose closing edge writes the last bit;
//              q/r are final in the following cycle
module div_core_u import div_pkg::*; #(
    parameter  int WIDTH = 8,
    parameter  int FBITS = 4,
    localparam int ITER  = div_iter(WIDTH, FBITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dvd_mag,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [ITER-1:0]  q,
    output logic [WIDTH:0]   r,
    output logic             done
);

    localparam int CW = $clog2(ITER);

    logic            run_q,  run_d;
    logic [CW-1:0]   cnt_q,  cnt_d;
    logic [ITER-1:0] dvd_q,  dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [ITER-1:0] quo_q,  quo_d;
    logic [WIDTH:0]  rem_q,  rem_d;
    logic [WIDTH:0]  rem_sh;

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        // Remainder stays below the divisor, so its top bit is always clear
        // before the shift and the shifted value fits WIDTH+1 bits.
        rem_sh = {rem_q[WIDTH-1:0], dvd_q[ITER-1]};
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            dvd_d = {dvd_mag, {FBITS{1'b0}}};
            dvs_d = dvs_mag;
            quo_d = '0;
            rem_d = '0;
        end else if (run_q) begin
            dvd_d = dvd_q << 1;
            if (rem_sh >= {1'b0, dvs_q}) begin
                rem_d = rem_sh - {1'b0, dvs_q};
                quo_d = {quo_q[ITER-2:0], 1'b1};
            end else begin
                rem_d = rem_sh;
                quo_d = {quo_q[ITER-2:0], 1'b0};
            end
            if (cnt_q == CW'(ITER - 1)) run_d = 1'b0;
            else                        cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign q    = quo_q;
    assign r    = rem_q;
    assign done = run_q && (cnt_q == CW'(ITER - 1));

endmodule

// File: rtl/div.sv
// div: signed Qm.n divider, val = a / b, round-half-to-even.
//   clk, rst - clock, synchronous active-high reset
//   bus      - div_if.slave: start/a/b in; busy/done/valid/ovf/dbz/val out
// done pulses ITER+2 clocks after an accepted start (1 clock for b == 0).
// val/valid/ovf/dbz hold until the next accepted start or reset.
module div import div_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int FBITS = 4
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    localparam int ITER = div_iter(WIDTH, FBITS);
    localparam logic [ITER:0] POS_MAX = (ITER+1)'((1 << (WIDTH-1)) - 1);
    localparam logic [ITER:0] NEG_MAX = (ITER+1)'(1 << (WIDTH-1));

    state_e           state_q;
    logic             sign_q;
    logic [WIDTH-1:0] bmag_q;
    logic [ITER:0]    qr_q;
    logic             busy_q, done_q, valid_q, ovf_q, dbz_q;
    logic [WIDTH-1:0] val_q;

    logic             accept, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [ITER-1:0]  q_c;
    logic [WIDTH:0]   r_c;
    logic             core_done;
    logic [WIDTH+1:0] r2, b2;
    logic             round_up, ovf_c;
    logic [WIDTH-1:0] qr_lo, res;

    assign accept = (state_q == IDLE) && bus.start;
    assign b_zero = (bus.b == '0);
    // Two's-complement negate of the most negative value wraps to itself,
    // which is the correct unsigned magnitude 2^(WIDTH-1).
    assign a_mag  = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign b_mag  = bus.b[WIDTH-1] ? -bus.b : bus.b;

    div_core_u #(.WIDTH(WIDTH), .FBITS(FBITS)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && !b_zero),
        .dvd_mag (a_mag),
        .dvs_mag (b_mag),
        .q       (q_c),
        .r       (r_c),
        .done    (core_done)
    );

    // Compare 2R with |b|: above half rounds up, exact half rounds to even.
    assign r2       = {r_c, 1'b0};
    assign b2       = {2'b00, bmag_q};
    assign round_up = (r2 > b2) || ((r2 == b2) && q_c[0]);

    assign ovf_c = sign_q ? (qr_q > NEG_MAX) : (qr_q > POS_MAX);
    assign qr_lo = qr_q[WIDTH-1:0];
    assign res   = sign_q ? -qr_lo : qr_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            bmag_q  <= '0;
            qr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            val_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    sign_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    bmag_q  <= b_mag;
                    valid_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    dbz_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= b_zero ? DBZ : CALC;
                end
                DBZ: begin
                    done_q  <= 1'b1;
                    dbz_q   <= 1'b1;
                    valid_q <= 1'b0;
                    val_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                CALC: if (core_done) state_q <= ROUND;
                ROUND: begin
                    qr_q    <= {1'b0, q_c} + (ITER+1)'(round_up);
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= !ovf_c;
                    ovf_q   <= ovf_c;
                    val_q   <= ovf_c ? '0 : res;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.ovf   = ovf_q;
    assign bus.dbz   = dbz_q;
    assign bus.val   = val_q;

endmodule

// File: tb/tb_div.sv
// tb_div: directed bench for div (Q4.4). A reference model computes each
// quotient with integer arithmetic and tracks the expected handshake
// timeline; a negedge process compares every output each cycle. Directed
// vectors additionally check hand-computed results and latencies.
module tb_div;

    localparam int W    = 8;
    localparam int F    = 4;
    localparam int ITER = W + F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;

    div_if #(.WIDTH(W)) bus ();

    div #(.WIDTH(W), .FBITS(F)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Result as {dbz, ovf, valid, val} from plain signed arithmetic.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b);
        int sa, sb, num, den, q, r;
        logic neg;
        logic [7:0] v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) return {1'b1, 1'b0, 1'b0, 8'h00};
        num = (sa < 0 ? -sa : sa) * (1 << F);
        den = sb < 0 ? -sb : sb;
        q = num / den;
        r = num % den;
        if (2*r > den || (2*r == den && q % 2 == 1)) q = q + 1;
        neg = (sa < 0) != (sb < 0);
        if (neg ? q > 128 : q > 127) return {1'b0, 1'b1, 1'b0, 8'h00};
        v = 8'(neg ? -q : q);
        return {1'b0, 1'b0, 1'b1, v};
    endfunction

    // Expected-behaviour timeline.
    logic        m_busy = 0, m_done = 0, m_valid = 0, m_ovf = 0, m_dbz = 0;
    logic [7:0]  m_val  = 0;
    logic [10:0] m_pend = 0;
    int          m_cnt  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_cnt <= 0;
            m_val <= 0; m_valid <= 0; m_ovf <= 0; m_dbz <= 0;
        end else begin
            m_done <= 0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1;
                    m_busy <= 0;
                    {m_dbz, m_ovf, m_valid, m_val} <= m_pend;
                end
            end else if (bus.start) begin
                m_busy  <= 1;
                m_valid <= 0; m_ovf <= 0; m_dbz <= 0;
                m_pend  <= model(bus.a, bus.b);
                m_cnt   <= (bus.b == 8'h00) ? 1 : ITER + 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy",  32'(bus.busy),  32'(m_busy));
            chk("cyc_done",  32'(bus.done),  32'(m_done));
            chk("cyc_valid", 32'(bus.valid), 32'(m_valid));
            chk("cyc_ovf",   32'(bus.ovf),   32'(m_ovf));
            chk("cyc_dbz",   32'(bus.dbz),   32'(m_dbz));
            chk("cyc_val",   32'(bus.val),   32'(m_val));
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string nm, input logic [7:0] ai, input logic [7:0] bi,
                       input logic [7:0] ev, input logic evld, input logic eovf,
                       input logic edbz, input int elat);
        int lat;
        @(posedge clk); #1;
        bus.a = ai; bus.b = bi; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        chk({nm, "_lat"},   32'(lat),       32'(elat));
        chk({nm, "_val"},   32'(bus.val),   32'(ev));
        chk({nm, "_valid"}, 32'(bus.valid), 32'(evld));
        chk({nm, "_ovf"},   32'(bus.ovf),   32'(eovf));
        chk({nm, "_dbz"},   32'(bus.dbz),   32'(edbz));
        chk({nm, "_model"}, 32'(model(ai, bi)), 32'({edbz, eovf, evld, ev}));
    endtask

    initial begin
        int lat, dn;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_valid", 32'(bus.valid), 32'(0));
        chk("reset_val",   32'(bus.val),   32'(0));
        chk("reset_busy",  32'(bus.busy),  32'(0));

        run("basic",    8'h30, 8'h20, 8'h18, 1, 0, 0, ITER + 2);
        run("third",    8'h10, 8'h30, 8'h05, 1, 0, 0, ITER + 2);
        run("tie_even", 8'h01, 8'h20, 8'h00, 1, 0, 0, ITER + 2);
        run("tie_odd",  8'h03, 8'h20, 8'h02, 1, 0, 0, ITER + 2);
        run("neg_a",    8'hD0, 8'h20, 8'hE8, 1, 0, 0, ITER + 2);
        run("neg_ab",   8'hD0, 8'hE0, 8'h18, 1, 0, 0, ITER + 2);
        run("min_ok",   8'h80, 8'h10, 8'h80, 1, 0, 0, ITER + 2);
        run("ovf_pos",  8'h70, 8'h08, 8'h00, 0, 1, 0, ITER + 2);
        run("ovf_min",  8'h80, 8'hF0, 8'h00, 0, 1, 0, ITER + 2);
        run("dbz",      8'h30, 8'h00, 8'h00, 0, 0, 1, 1);
        run("dbz_clr",  8'h30, 8'h20, 8'h18, 1, 0, 0, ITER + 2);
        run("neg_zero", 8'h01, 8'hC0, 8'h00, 1, 0, 0, ITER + 2);

        // Start pulsed while busy must be ignored.
        @(posedge clk); #1;
        bus.a = 8'h10; bus.b = 8'h30; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.a = 8'h70; bus.b = 8'h08; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        chk("ign_lat",   32'(lat),       32'(ITER + 2 - 4));
        chk("ign_val",   32'(bus.val),   32'(8'h05));
        chk("ign_valid", 32'(bus.valid), 32'(1));

        // Reset five cycles into a division.
        @(posedge clk); #1;
        bus.a = 8'h30; bus.b = 8'h20; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy",  32'(bus.busy),  32'(0));
        chk("rst_valid", 32'(bus.valid), 32'(0));
        chk("rst_val",   32'(bus.val),   32'(0));
        dn = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dn++;
        end
        chk("rst_no_done", 32'(dn), 32'(0));

        // Start in the done cycle is accepted.
        @(posedge clk); #1;
        bus.a = 8'h30; bus.b = 8'h20; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        chk("b2b_first", 32'(bus.val), 32'(8'h18));
        bus.a = 8'hD0; bus.b = 8'h20; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        chk("b2b_lat", 32'(lat),     32'(ITER + 2));
        chk("b2b_val", 32'(bus.val), 32'(8'hE8));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
